// File: rtl/mult_div_unit.sv
// Sequential multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, sign fix-up at the end.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             wr_hi_i,
    input  logic             wr_lo_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q;
    logic [1:0]         op_q;
    logic               sign_a_q;
    logic               sign_b_q;
    logic               zero_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_part;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        a_neg = op_i[0] & a_i[WIDTH-1];
        b_neg = op_i[0] & b_i[WIDTH-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;

        // Multiplier sits in the low half and is consumed LSB first as the product shifts in.
        mul_add  = acc_q[0] ? {1'b0, opnd_q} : '0;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + mul_add;
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Upper half is the partial remainder, lower half shifts dividend out and quotient in.
        div_part = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge   = div_part >= {1'b0, opnd_q};
        div_rem  = div_part[WIDTH-1:0] - opnd_q;
        div_next = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                          : {acc_q[2*WIDTH-2:0], 1'b0};

        prod = (op_q[0] && (sign_a_q != sign_b_q)) ? -acc_q : acc_q;
        quot = (op_q[0] && (sign_a_q != sign_b_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = (op_q[0] && sign_a_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= 2'b00;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        op_q     <= op_i;
                        sign_a_q <= a_neg;
                        sign_b_q <= b_neg;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        if (op_i[1]) begin
                            opnd_q <= b_mag;
                            acc_q  <= {{WIDTH{1'b0}}, a_mag};
                            zero_q <= (b_i == '0);
                            state_q <= (b_i == '0) ? StFix : StRun;
                        end else begin
                            opnd_q  <= a_mag;
                            acc_q   <= {{WIDTH{1'b0}}, b_mag};
                            zero_q  <= 1'b0;
                            state_q <= StRun;
                        end
                    end else begin
                        if (wr_hi_i) hi_q <= a_i;
                        if (wr_lo_i) lo_q <= a_i;
                    end
                end
                StRun: begin
                    acc_q <= op_q[1] ? div_next : mul_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) state_q <= StFix;
                end
                StFix: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    if (zero_q) begin
                        dbz_q <= 1'b1;
                    end else if (op_q[1]) begin
                        hi_q <= rem;
                        lo_q <= quot;
                    end else begin
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random operations
// compared against a plain-arithmetic reference model of HI/LO.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        wr_hi_i;
    logic        wr_lo_i;
    logic        busy_o;
    logic        done_o;
    logic        div_by_zero_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .op_i         (op_i),
        .a_i          (a_i),
        .b_i          (b_i),
        .wr_hi_i      (wr_hi_i),
        .wr_lo_i      (wr_lo_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .div_by_zero_o(div_by_zero_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi_in, input logic [31:0] lo_in,
                                   output logic [31:0] hi, output logic [31:0] lo,
                                   output logic dz);
        int          sa;
        int          sb;
        longint      p;
        logic [63:0] up;
        sa = a;
        sb = b;
        hi = hi_in;
        lo = lo_in;
        dz = 1'b0;
        case (op)
            2'd0: begin
                up = {32'h0, a} * {32'h0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            2'd1: begin
                p  = longint'(sa) * longint'(sb);
                up = p;
                hi = up[63:32];
                lo = up[31:0];
            end
            2'd2: begin
                if (b == 0) dz = 1'b1;
                else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: begin
                if (b == 0) dz = 1'b1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'h0;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
        endcase
    endfunction

    task automatic write_hilo(input logic h, input logic l, input logic [31:0] v);
        @(negedge clk);
        wr_hi_i = h;
        wr_lo_i = l;
        a_i     = v;
        @(negedge clk);
        wr_hi_i = 1'b0;
        wr_lo_i = 1'b0;
        if (h) m_hi = v;
        if (l) m_lo = v;
        check_val("mthi", {32'h0, hi_o}, {32'h0, m_hi});
        check_val("mtlo", {32'h0, lo_o}, {32'h0, m_lo});
    endtask

    // mode 0: plain, 1: start+mthi attempt mid-flight, 2: reset mid-flight
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic with_wr, input int mode);
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_dz;
        int          n;
        ref_op(op, a, b, m_hi, m_lo, e_hi, e_lo, e_dz);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        wr_hi_i = with_wr;
        wr_lo_i = with_wr;
        @(negedge clk);
        start_i = 1'b0;
        wr_hi_i = 1'b0;
        wr_lo_i = 1'b0;
        n = 0;
        check_val("busy_start", {63'h0, busy_o}, 64'h1);
        while (!done_o && n < 60) begin
            @(negedge clk);
            n++;
            if (mode == 1 && n == 5) begin
                start_i = 1'b1;
                op_i    = 2'd2;
                a_i     = 32'd100;
                b_i     = 32'd7;
                wr_hi_i = 1'b1;
            end else if (mode == 1 && n == 6) begin
                start_i = 1'b0;
                wr_hi_i = 1'b0;
            end
            if (mode == 2 && n == 10) begin
                reset = 1'b1;
                #1;
                check_val("rst_mid_outs", {hi_o, lo_o}, 64'h0);
                check_val("rst_mid_flags", {61'h0, busy_o, done_o, div_by_zero_o}, 64'h0);
                @(negedge clk);
                reset = 1'b0;
                m_hi  = '0;
                m_lo  = '0;
                @(negedge clk);
                check_val("rst_mid_idle", {63'h0, busy_o}, 64'h0);
                return;
            end
            if (n == 16 && !done_o)
                check_val("hilo_hold", {hi_o, lo_o}, {m_hi, m_lo});
        end
        check_val("latency", 64'(n), e_dz ? 64'd1 : 64'd33);
        check_val("hi", {32'h0, hi_o}, {32'h0, e_hi});
        check_val("lo", {32'h0, lo_o}, {32'h0, e_lo});
        check_val("dbz", {63'h0, div_by_zero_o}, {63'h0, e_dz});
        check_val("busy_end", {63'h0, busy_o}, 64'h0);
        m_hi = e_hi;
        m_lo = e_lo;
        @(negedge clk);
        check_val("done_pulse", {62'h0, done_o, div_by_zero_o}, 64'h0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        reset   = 1'b1;
        start_i = 1'b0;
        op_i    = 2'd0;
        a_i     = '0;
        b_i     = '0;
        wr_hi_i = 1'b0;
        wr_lo_i = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_outs", {hi_o, lo_o}, 64'h0);
        check_val("rst_flags", {61'h0, busy_o, done_o, div_by_zero_o}, 64'h0);
        reset = 1'b0;

        do_op(2'd0, 32'd7, 32'd6, 1'b0, 0);
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(2'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 0);
        do_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        do_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        write_hilo(1'b0, 1'b1, 32'h1234);
        write_hilo(1'b1, 1'b0, 32'h5678);
        do_op(2'd2, 32'd9, 32'd0, 1'b0, 0);
        do_op(2'd3, 32'hDEAD_BEEF, 32'd0, 1'b0, 0);
        write_hilo(1'b1, 1'b1, 32'hCAFE_0001);
        do_op(2'd0, 32'd3, 32'd4, 1'b0, 1);
        do_op(2'd1, 32'h1234_5678, 32'h8765_4321, 1'b1, 0);
        do_op(2'd0, 32'd11, 32'd13, 1'b0, 2);
        do_op(2'd0, 32'd11, 32'd13, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = 32'($urandom_range(1, 9));
                2: a = 32'($urandom_range(0, 300));
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            if ($urandom_range(0, 5) == 0)
                write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            do_op(op, a, b, 1'($urandom_range(0, 3) == 0), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Sequential 32-bit multiply/divide unit for the MIPS datapath, operating beside the ALU on the same register operands. The ALU executes `add`, `sub`, `or`, `lui`, `sll`, `srl` and `jr` in one cycle; this unit executes `mult`, `multu`, `div` and `divu` over multiple cycles. It holds results in architectural HI/LO registers, which feed the writeback mux for `mfhi`/`mflo`. The unit exposes a start/busy/done handshake so the control unit can stall the PC while an operation is in flight.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. The iteration count equals `WIDTH`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  request an operation; sampled only in IDLE.
- `op_i`  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a_i`  in  WIDTH  rs operand: multiplicand or dividend; also the data for mthi/mtlo.
- `b_i`  in  WIDTH  rt operand: multiplier or divisor.
- `wr_hi_i`  in  1  mthi: write `a_i` into HI (IDLE only).
- `wr_lo_i`  in  1  mtlo: write `a_i` into LO (IDLE only).
- `busy_o`  out  1  operation in flight.
- `done_o`  out  1  one-cycle pulse; HI/LO final.
- `div_by_zero_o`  out  1  one-cycle pulse coincident with `done_o` when a divide had `b_i`=0.
- `hi_o`  out  WIDTH  HI register (product upper half / remainder).
- `lo_o`  out  WIDTH  LO register (product lower half / quotient).

## Operation
- **States:** IDLE, RUN, FIX.
- **IDLE + `start_i`:** latch `op_i`.
  - For signed ops, latch magnitudes |a|, |b| plus the sign of a, the sign of b, and the sign of the dividend.
  - Clear the iteration counter, go to RUN.
  - For DIV/DIVU with `b_i`=0: go directly to FIX with the zero flag set.
- **RUN, multiply:** radix-2 shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- **RUN, divide:** restoring division, one quotient bit per cycle.
- **RUN exit:** after exactly WIDTH iterations (counter WIDTH−1), go to FIX.
- **FIX:** apply sign correction, write HI/LO, go to IDLE.
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Zero-divisor case: HI and LO remain unchanged; only `done_o` and `div_by_zero_o` pulse.
- **Arithmetic rules:**
  - All arithmetic is modulo 2^WIDTH per half.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, no flag.
  - MULTU/DIVU treat operands as unsigned.
- **mthi/mtlo:** `wr_hi_i`/`wr_lo_i` write HI/LO from `a_i` in IDLE only; both may assert in the same cycle.
- **`start_i` while busy:** ignored; no queuing.
- **`wr_hi_i`/`wr_lo_i` while busy:** ignored.
- **`start_i` and `wr_*_i` together in IDLE:** `start_i` wins and the write is dropped.
- **`reset` (any time, including mid-operation):** state=IDLE, counter=0, accumulators=0, `hi_o`=0, `lo_o`=0, `busy_o`=0, `done_o`=0, `div_by_zero_o`=0. Any in-flight result is discarded.

## Timing
- Let E0 be the edge that samples `start_i`.
- **Normal operation:**
  - `busy_o` goes high after E0.
  - Iterations occur on edges E1..E32.
  - FIX runs on E33, which writes HI/LO.
  - After E33: `busy_o`=0, `done_o`=1 for exactly one cycle, and `hi_o`/`lo_o` show final values.
  - Latency is 33 cycles from the start edge to result.
- **Divide by zero:**
  - `busy_o` is high only for the cycle after E0.
  - E1 executes FIX.
  - `done_o` and `div_by_zero_o` are high for the cycle after E1.
- **Back-to-back:** a new `start_i` may be accepted in the same cycle `done_o` is high, because the unit is already in IDLE.
- **Intermediate values:** `hi_o`/`lo_o` never show intermediate values; they change only in FIX or on an IDLE mthi/mtlo edge.
- **Outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- MULTU a=7, b=6 -> `done_o` pulses 33 cycles after start; HI=0x00000000, LO=0x0000002A; `busy_o` high for cycles 1–33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (−3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (−7), b=2 -> LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload via mtlo 0x1234 and mthi 0x5678, then DIVU a=9, b=0 -> `done_o` and `div_by_zero_o` pulse 1 cycle after start; HI=0x5678, LO=0x1234.
- Start MULTU 3×4, assert `start_i` (DIVU 100/7) and `wr_hi_i` at cycle 5 -> both ignored; LO=12.
- Start another MULTU, assert `reset` at cycle 10 -> all outputs 0 immediately, state IDLE; a new start afterwards completes in 33 cycles.
